// File: rtl/mcac_pkg.sv
// Shared definitions for the MCAC channel scheduler.
//   sched_state_t : scheduler FSM state encoding
//   MCAC_NCH      : channels per frame
//   MCAC_CHW      : channel index width (MCAC_NCH == 2**MCAC_CHW)
package mcac_pkg;

  localparam int unsigned MCAC_NCH = 32;
  localparam int unsigned MCAC_CHW = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/mcac_tr_pending.sv
// Per-channel TR pending register.
//   set/set_ch : mark a TR pending on set_ch
//   clr/clr_ch : consume the pending TR of clr_ch
//   pend       : pending bits, one per channel
// A set and a clear of the same bit in one cycle leaves the bit set.
module mcac_tr_pending
  import mcac_pkg::*;
#(
  parameter int unsigned NCH = MCAC_NCH,
  parameter int unsigned CHW = MCAC_CHW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           set,
  input  logic [CHW-1:0] set_ch,
  input  logic           clr,
  input  logic [CHW-1:0] clr_ch,
  output logic [NCH-1:0] pend
);

  logic [NCH-1:0] pend_nxt;

  // Clear first, then set, so a coincident set survives.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < NCH; i++) begin
      if (clr && (clr_ch == CHW'(i))) pend_nxt[i] = 1'b0;
      if (set && (set_ch == CHW'(i))) pend_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pend_nxt;
  end

endmodule

// File: rtl/mcac_chan_sched.sv
// Channel scheduler for the shared ADPCM datapath.
// Each frame walks the enabled channels in ascending order, issuing a
// start/done handshake per channel with a one-shot TR flag.
//   clk, reset            : clock, synchronous active-high reset
//   scan_*, test_mode     : DFT hooks (chains inserted at synthesis)
//   frame_sync, ch_enable : frame start pulse and per-channel enable mask
//   tr_set, tr_ch         : request a TR on a channel
//   clr_err               : clear sticky overrun/timeout flags
//   dp_start/dp_ch/dp_tr  : datapath issue interface
//   dp_done               : datapath completion pulse
//   busy, frame_done      : status
//   overrun, timeout      : sticky error flags
module mcac_chan_sched
  import mcac_pkg::*;
#(
  parameter int unsigned NCH    = MCAC_NCH,
  parameter int unsigned CHW    = MCAC_CHW,
  parameter int unsigned TO_CYC = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           scan_in0,
  input  logic           scan_in1,
  input  logic           scan_in2,
  input  logic           scan_in3,
  input  logic           scan_in4,
  input  logic           scan_enable,
  input  logic           test_mode,
  output logic           scan_out0,
  output logic           scan_out1,
  output logic           scan_out2,
  output logic           scan_out3,
  output logic           scan_out4,
  input  logic           frame_sync,
  input  logic [NCH-1:0] ch_enable,
  input  logic           tr_set,
  input  logic [CHW-1:0] tr_ch,
  input  logic           clr_err,
  output logic           dp_start,
  output logic [CHW-1:0] dp_ch,
  output logic           dp_tr,
  input  logic           dp_done,
  output logic           busy,
  output logic           frame_done,
  output logic           overrun,
  output logic           timeout
);

  localparam int unsigned    TW      = $clog2(TO_CYC + 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TO_CYC - 1);

  // Scan chains are stitched by the DFT flow; tie off at RTL.
  logic unused_dft;
  assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                        scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  sched_state_t   state, state_nxt;
  logic [CHW-1:0] idx, idx_nxt;
  logic [NCH-1:0] en_snap, en_snap_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic [NCH-1:0] tr_pend;
  logic           tr_bit;
  logic           expire, to_set, ovr_set;
  logic           dp_start_nxt, dp_tr_nxt, busy_nxt, frame_done_nxt;
  logic           overrun_nxt, timeout_nxt;
  logic [CHW-1:0] dp_ch_nxt;

  mcac_tr_pending #(.NCH(NCH), .CHW(CHW)) u_tr_pending (
    .clk    (clk),
    .reset  (reset),
    .set    (tr_set),
    .set_ch (tr_ch),
    .clr    (state == ISSUE),
    .clr_ch (idx),
    .pend   (tr_pend)
  );

  // TR value the ISSUE cycle will see, including a set landing this cycle.
  assign tr_bit = tr_pend[idx] | (tr_set && (tr_ch == idx));
  assign expire = (timer == TO_LAST);

  // Next-state, counters, flags and registered-output decode.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    en_snap_nxt = en_snap;
    timer_nxt   = timer;
    to_set      = 1'b0;
    ovr_set     = frame_sync && (state != IDLE);

    case (state)
      IDLE: begin
        if (frame_sync) begin
          en_snap_nxt = ch_enable;
          idx_nxt     = '0;
          state_nxt   = SCAN;
        end
      end
      SCAN: begin
        if (en_snap[idx])         state_nxt = ISSUE;
        else if (idx == LAST_CH)  state_nxt = DONE;
        else                      idx_nxt   = idx + CHW'(1);
      end
      ISSUE: begin
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        timer_nxt = timer + TW'(1);
        // A done coinciding with expiry counts as done.
        to_set    = expire && !dp_done;
        if (dp_done || expire) begin
          if (idx == LAST_CH) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + CHW'(1);
            state_nxt = SCAN;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt       = (state_nxt != IDLE);
    dp_start_nxt   = (state_nxt == ISSUE);
    frame_done_nxt = (state_nxt == DONE);
    dp_ch_nxt      = ((state_nxt == ISSUE) || (state_nxt == WAIT)) ? idx_nxt : '0;
    if (state_nxt == ISSUE)     dp_tr_nxt = tr_bit;
    else if (state_nxt == WAIT) dp_tr_nxt = dp_tr;
    else                        dp_tr_nxt = 1'b0;

    overrun_nxt = ovr_set | (overrun & ~clr_err);
    timeout_nxt = to_set  | (timeout & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      en_snap    <= '0;
      timer      <= '0;
      dp_start   <= 1'b0;
      dp_ch      <= '0;
      dp_tr      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      en_snap    <= en_snap_nxt;
      timer      <= timer_nxt;
      dp_start   <= dp_start_nxt;
      dp_ch      <= dp_ch_nxt;
      dp_tr      <= dp_tr_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      overrun    <= overrun_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_mcac_chan_sched.sv
// Self-checking bench for mcac_chan_sched (NCH=32, TO_CYC=8).
// Frame cycles are counted from the frame_sync sampling edge: cycle 1 is
// the first cycle after it. Expected frame_done cycle for a frame is
// NCH+1 plus (1+k) per enabled channel, k = WAIT cycles for that channel.
module tb_mcac_chan_sched;

  localparam int unsigned NCH = 32;
  localparam int unsigned CHW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_sync;
  logic [NCH-1:0] ch_enable;
  logic           tr_set;
  logic [CHW-1:0] tr_ch;
  logic           clr_err;
  logic           dp_start;
  logic [CHW-1:0] dp_ch;
  logic           dp_tr;
  logic           dp_done;
  logic           busy;
  logic           frame_done;
  logic           overrun;
  logic           timeout;
  logic [4:0]     scan_out_unused;

  int n_chk  = 0;
  int n_fail = 0;

  mcac_chan_sched #(.NCH(NCH), .CHW(CHW), .TO_CYC(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (1'b0),
    .scan_in1    (1'b0),
    .scan_in2    (1'b0),
    .scan_in3    (1'b0),
    .scan_in4    (1'b0),
    .scan_enable (1'b0),
    .test_mode   (1'b0),
    .scan_out0   (scan_out_unused[0]),
    .scan_out1   (scan_out_unused[1]),
    .scan_out2   (scan_out_unused[2]),
    .scan_out3   (scan_out_unused[3]),
    .scan_out4   (scan_out_unused[4]),
    .frame_sync  (frame_sync),
    .ch_enable   (ch_enable),
    .tr_set      (tr_set),
    .tr_ch       (tr_ch),
    .clr_err     (clr_err),
    .dp_start    (dp_start),
    .dp_ch       (dp_ch),
    .dp_tr       (dp_tr),
    .dp_done     (dp_done),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] en;
    int          d;        // dp_done delay after dp_start, 0 = never
    int          nst;
    int          ch_first;
    int          ch_last;
    int          fd;
    int          to;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Run one frame, answering each dp_start with dp_done after d cycles.
  task automatic run_frame(input logic [31:0] en, input int d, input bit tr_on_issue,
                           input int sync_at, input int clr_at,
                           output int nst, output int ch_first, output int ch_last,
                           output int tr_first, output int fd_cyc, output int extra_bad);
    int done_at;
    bit seen_fd;
    nst = 0; ch_first = -1; ch_last = -1; tr_first = -1; fd_cyc = -1;
    extra_bad = 0; done_at = -1; seen_fd = 1'b0;
    @(negedge clk);
    ch_enable  = en;
    frame_sync = 1'b1;
    for (int c = 1; c <= 400 && !seen_fd; c++) begin
      @(negedge clk);
      frame_sync = (c == sync_at);
      clr_err    = (c == clr_at);
      dp_done    = 1'b0;
      tr_set     = 1'b0;
      if (!busy) extra_bad++;
      if (dp_start) begin
        if (nst == 0) begin
          ch_first = int'(dp_ch);
          tr_first = int'(dp_tr);
        end
        ch_last = int'(dp_ch);
        nst++;
        if (d > 0) done_at = c + d;
        if (tr_on_issue) begin
          tr_set = 1'b1;
          tr_ch  = dp_ch;
        end
      end
      if (c == done_at) dp_done = 1'b1;
      if (frame_done) begin
        fd_cyc  = c;
        seen_fd = 1'b1;
      end
    end
    frame_sync = 1'b0; clr_err = 1'b0; dp_done = 1'b0; tr_set = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (busy || frame_done || dp_start) extra_bad++;
    end
  endtask

  int nst, chf, chl, trf, fdc, xb;
  bit got_start;

  initial begin
    vecs[0] = '{32'h0000_0005, 3,  2, 0,  2, 41, 0};
    vecs[1] = '{32'h0000_0000, 3,  0, -1, -1, 33, 0};
    vecs[2] = '{32'h0000_0001, 0,  1, 0,  0, 42, 1};
    vecs[3] = '{32'h0000_0001, 1,  1, 0,  0, 35, 0};
    vecs[4] = '{32'h8000_0001, 2,  2, 0, 31, 39, 0};
    vecs[5] = '{32'hFFFF_FFFF, 1, 32, 0, 31, 97, 0};
    vecs[6] = '{32'h0000_0004, 8,  1, 2,  2, 42, 0};  // done on expiry cycle

    reset = 1'b1; frame_sync = 1'b0; ch_enable = '0; tr_set = 1'b0;
    tr_ch = '0; clr_err = 1'b0; dp_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({dp_start, dp_ch, dp_tr, busy, frame_done, overrun, timeout}), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      pulse_clr();
      run_frame(vecs[i].en, vecs[i].d, 1'b0, 0, 0, nst, chf, chl, trf, fdc, xb);
      check($sformatf("v%0d_nstarts", i), nst, vecs[i].nst);
      check($sformatf("v%0d_ch_first", i), chf, vecs[i].ch_first);
      check($sformatf("v%0d_ch_last", i), chl, vecs[i].ch_last);
      check($sformatf("v%0d_tr_first", i), trf, (vecs[i].nst > 0) ? 0 : -1);
      check($sformatf("v%0d_frame_done_cyc", i), fdc, vecs[i].fd);
      check($sformatf("v%0d_timeout", i), int'(timeout), vecs[i].to);
      check($sformatf("v%0d_overrun", i), int'(overrun), 0);
      check($sformatf("v%0d_busy_profile", i), xb, 0);
    end

    // TR set while idle is delivered once, on channel 2.
    @(negedge clk); tr_set = 1'b1; tr_ch = 5'd2;
    @(negedge clk); tr_set = 1'b0;
    run_frame(32'h4, 2, 1'b0, 0, 0, nst, chf, chl, trf, fdc, xb);
    check("tr_ch", chf, 2);
    check("tr_first_frame", trf, 1);
    run_frame(32'h4, 2, 1'b0, 0, 0, nst, chf, chl, trf, fdc, xb);
    check("tr_second_frame", trf, 0);

    // TR set in the ISSUE cycle of its channel: old value issued, set survives.
    run_frame(32'h4, 2, 1'b1, 0, 0, nst, chf, chl, trf, fdc, xb);
    check("tr_setwins_issue", trf, 0);
    run_frame(32'h4, 2, 1'b0, 0, 0, nst, chf, chl, trf, fdc, xb);
    check("tr_setwins_next", trf, 1);
    run_frame(32'h4, 2, 1'b0, 0, 0, nst, chf, chl, trf, fdc, xb);
    check("tr_setwins_after", trf, 0);

    // Timeout is sticky until clr_err.
    run_frame(32'h1, 0, 1'b0, 0, 0, nst, chf, chl, trf, fdc, xb);
    check("timeout_set", int'(timeout), 1);
    pulse_clr();
    @(negedge clk);
    check("timeout_cleared", int'(timeout), 0);

    // Mid-frame frame_sync: overrun, frame runs to completion, one frame_done.
    run_frame(32'h5, 3, 1'b0, 10, 0, nst, chf, chl, trf, fdc, xb);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_frame_done_cyc", fdc, 41);
    check("ovr_nstarts", nst, 2);
    check("ovr_single_frame", xb, 0);
    run_frame(32'h5, 3, 1'b0, 10, 10, nst, chf, chl, trf, fdc, xb);
    check("ovr_set_beats_clr", int'(overrun), 1);
    pulse_clr();
    @(negedge clk);
    check("ovr_cleared", int'(overrun), 0);

    // Reset while waiting on channel 5.
    got_start = 1'b0;
    @(negedge clk); ch_enable = 32'h20; frame_sync = 1'b1;
    for (int c = 0; c < 50 && !got_start; c++) begin
      @(negedge clk);
      frame_sync = 1'b0;
      if (dp_start) begin
        got_start = 1'b1;
        check("rst_issue_ch", int'(dp_ch), 5);
      end
    end
    check("rst_got_start", int'(got_start), 1);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("rst_midframe_outputs",
          int'({dp_start, dp_ch, dp_tr, busy, frame_done, overrun, timeout}), 0);
    reset = 1'b0;
    run_frame(32'h1, 2, 1'b0, 0, 0, nst, chf, chl, trf, fdc, xb);
    check("post_rst_ch_first", chf, 0);
    check("post_rst_frame_done_cyc", fdc, 36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcac_chan_sched.md
# mcac_chan_sched

Channel scheduler for the single shared ADPCM resource. Each frame, it walks the enabled channels in ascending order and hands each one to the shared datapath with a start/done handshake. For every channel it supplies the channel index and a one-shot TR (transition) flag for the TRIGB coefficient-reset path. It also flags frame overruns and datapath timeouts.

## Interface
Parameters:
- NCH, 32, number of channels per frame
- CHW, 5, channel index width; NCH must equal 2**CHW
- TO_CYC, 255, WAIT-state cycles before a datapath timeout; must be at least 1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scan_in0..scan_in4  in  1  scan chain inputs
- scan_enable  in  1  scan shift enable
- test_mode  in  1  DFT test mode
- scan_out0..scan_out4  out  1  scan chain outputs
- frame_sync  in  1  one-cycle pulse that starts a frame
- ch_enable  in  NCH  per-channel enable mask, sampled on frame start
- tr_set  in  1  request a TR on channel tr_ch
- tr_ch  in  CHW  channel targeted by tr_set
- clr_err  in  1  clears the overrun and timeout flags
- dp_start  out  1  one-cycle start pulse to the datapath
- dp_ch  out  CHW  channel being processed
- dp_tr  out  1  TR for the current channel; drives the TRIGB TR input
- dp_done  in  1  datapath completion pulse
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle end-of-frame pulse
- overrun  out  1  sticky: frame_sync arrived while busy
- timeout  out  1  sticky: dp_done was missing for TO_CYC cycles

## Operation
States: IDLE, SCAN, ISSUE, WAIT, DONE.
- **IDLE**
  - On frame_sync: latch ch_enable into en_snap, set idx=0, go to SCAN.
- **SCAN**
  - If en_snap[idx]=1: go to ISSUE.
  - Else, if idx=NCH-1: go to DONE.
  - Else: idx+1, stay in SCAN. Each skipped channel costs one cycle.
- **ISSUE** (one cycle)
  - dp_start=1, dp_ch=idx, dp_tr=tr_pend[idx].
  - Clear tr_pend[idx]. Clear the timer. Go to WAIT.
- **WAIT**
  - dp_ch holds idx. dp_tr holds the value issued in ISSUE.
  - The timer increments every cycle.
  - On dp_done: advance.
  - Else, when timer reaches TO_CYC-1: set timeout, advance.
  - Advance means: if idx=NCH-1 go to DONE, else idx+1 and go to SCAN.
- **DONE**
  - frame_done=1 for one cycle, then go to IDLE.

TR pending register (tr_pend, NCH bits):
- tr_set sets tr_pend[tr_ch].
- If tr_set hits the same channel in the same cycle that ISSUE clears it, the set wins: the bit stays 1 for the next frame, and the current issue uses the old value.

Error flags:
- frame_sync in any state other than IDLE is ignored and sets overrun. The current frame continues.
- A set and clr_err in the same cycle: the set wins.
- dp_done outside WAIT is ignored.
- dp_done in the same cycle the timer expires counts as done; no timeout is recorded.

## Timing
- **Reset:** state=IDLE, idx=0, en_snap=0, tr_pend=0, timer=0. All outputs 0: dp_start, dp_ch, dp_tr, busy, frame_done, overrun, timeout. Reset mid-frame aborts the frame immediately, with no frame_done.
- All outputs are registered, Moore-style, and decoded from state and registers.
- **Frame start:** frame_sync sampled high at edge E gives SCAN, busy=1 from E+1. If channel 0 is enabled, dp_start=1 in cycle E+2.
- **Per enabled channel:** 1 SCAN + 1 ISSUE + k WAIT cycles, where dp_done arrives in the k-th WAIT cycle.
- **Per disabled channel:** 1 SCAN cycle.
- **Frame end:** frame_done follows the last channel's advance by one cycle. busy falls on the cycle after frame_done.
- **All channels disabled:** frame_done in cycle E+NCH+1.
- The timer width is ceil(log2(TO_CYC+1)) bits.
- idx never wraps. Termination is decided at idx=NCH-1.

## Structure
- Shared package mcac_pkg holds:
  - the state enum (sched_state_t: IDLE, SCAN, ISSUE, WAIT, DONE);
  - MCAC_NCH=32 and MCAC_CHW=5.
- One sub-module, mcac_tr_pending: the NCH-bit TR set/clear register, including the set-wins rule.
- The FSM, idx counter, timer and error flags live in mcac_chan_sched.

## Test plan
- ch_enable=32'h0000_0005, dp_done 3 cycles after each dp_start -> dp_start with dp_ch=0 then dp_ch=2 only; frame_done at the expected cycle; overrun=0, timeout=0.
- tr_set with tr_ch=2, then a frame with ch_enable=32'h4 -> dp_tr=1 with dp_ch=2. Next frame -> dp_tr=0.
- ch_enable=0 -> no dp_start; frame_done exactly NCH+1 cycles after frame_sync.
- ch_enable=1, dp_done never asserted, TO_CYC=8 -> timeout=1 after 8 WAIT cycles; frame_done follows; clr_err clears timeout.
- Second frame_sync mid-frame -> overrun=1; exactly one frame_done. clr_err coincident with a new overrun -> overrun stays 1.
- reset asserted in WAIT on channel 5 -> next cycle all outputs 0 and state IDLE; a later frame starts at channel 0.
